// File: rtl/psum_requant_writeback.sv
// psum_requant_writeback
// Reads a finished layer's psums from the GLB psum bank. Each psum goes through
// an optional ReLU, a rounded arithmetic right shift and saturation to signed
// int8. Four results are packed per word and written to the GLB ifmap bank as
// the next layer's ifmap. The stage handles one element per cycle and has no
// backpressure.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               start pulse; accepted only in IDLE
//   i_src_base/i_dst_base first psum read address / first ifmap write address
//   i_num_elem            psum count (0..2^ADDR_BITWIDTH)
//   i_shift, i_relu_en    requantization controls, latched at start
//   o_busy, o_done        job active / one-cycle completion pulse
//   o_psum_rd_*           psum bank read port; data returns one cycle later
//   o_ifmap_wr_*          ifmap bank write port (packed int8 words)
module psum_requant_writeback #(
    parameter int unsigned DATA_BITWIDTH  = 32,
    parameter int unsigned ADDR_BITWIDTH  = 13,
    parameter int unsigned OUT_BITWIDTH   = 8,
    parameter int unsigned SHIFT_BITWIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [ADDR_BITWIDTH-1:0]  i_src_base,
    input  logic [ADDR_BITWIDTH-1:0]  i_dst_base,
    input  logic [ADDR_BITWIDTH:0]    i_num_elem,
    input  logic [SHIFT_BITWIDTH-1:0] i_shift,
    input  logic                      i_relu_en,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_psum_rd_en,
    output logic [ADDR_BITWIDTH-1:0]  o_psum_rd_addr,
    input  logic [DATA_BITWIDTH-1:0]  i_psum_rd_data,
    output logic                      o_ifmap_wr_en,
    output logic [ADDR_BITWIDTH-1:0]  o_ifmap_wr_addr,
    output logic [DATA_BITWIDTH-1:0]  o_ifmap_wr_data
);

    localparam int unsigned LANES     = DATA_BITWIDTH / OUT_BITWIDTH;
    localparam int unsigned LANE_BITS = $clog2(LANES);
    localparam int unsigned CNT_BITS  = ADDR_BITWIDTH + 1;
    localparam int unsigned SUM_W     = DATA_BITWIDTH + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (OUT_BITWIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    // Control registers
    logic [2:0]               r_state;
    logic [CNT_BITS-1:0]      r_cnt;
    logic                     r_rd_en;
    logic [ADDR_BITWIDTH-1:0] r_rd_addr;
    logic                     r_busy;
    logic                     r_done;

    // Datapath registers
    logic [SHIFT_BITWIDTH-1:0] r_shift;
    logic                      r_relu;
    logic                      r_vld;
    logic                      r_vld_last;
    logic [LANE_BITS-1:0]      r_lane;
    logic [DATA_BITWIDTH-1:0]  r_pack;
    logic                      r_wr_en;
    logic [ADDR_BITWIDTH-1:0]  r_wr_addr;
    logic [DATA_BITWIDTH-1:0]  r_wr_data;
    logic [ADDR_BITWIDTH-1:0]  r_wr_ptr;

    // Next-state values
    logic [2:0]               w_state_nxt;
    logic [CNT_BITS-1:0]      w_cnt_nxt;
    logic                     w_rd_en_nxt;
    logic [ADDR_BITWIDTH-1:0] w_rd_addr_nxt;
    logic                     w_busy_nxt;
    logic                     w_done_nxt;
    logic                     w_accept;
    logic                     w_issue_last;

    // Requantization datapath
    logic signed [DATA_BITWIDTH-1:0] w_relu_val;
    logic signed [SUM_W-1:0]         w_ext;
    logic        [SUM_W-1:0]         w_rnd;
    logic signed [SUM_W-1:0]         w_sum;
    logic signed [SUM_W-1:0]         w_shifted;
    logic        [OUT_BITWIDTH-1:0]  w_q;
    logic        [DATA_BITWIDTH-1:0] w_word;

    // The read issued while r_cnt is zero is the job's final read
    assign w_issue_last = (r_state == S_READ) && (r_cnt == '0);

    // Next-state logic: r_cnt holds the number of reads still to issue after the current one
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    if (i_num_elem == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_READ;
                        w_rd_en_nxt   = 1'b1;
                        w_rd_addr_nxt = i_src_base;
                        w_cnt_nxt     = i_num_elem - CNT_BITS'(1);
                        w_busy_nxt    = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = r_rd_addr + ADDR_BITWIDTH'(1);
                    w_cnt_nxt     = r_cnt - CNT_BITS'(1);
                end
            end
            S_DRAIN: w_state_nxt = S_FLUSH;
            S_FLUSH: begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // ReLU, rounded arithmetic shift (33-bit sum cannot overflow), saturate to int8
    always_comb begin
        w_relu_val = $signed(i_psum_rd_data);
        if (r_relu && w_relu_val[DATA_BITWIDTH-1]) begin
            w_relu_val = '0;
        end
        w_ext     = SUM_W'(w_relu_val);
        w_rnd     = (r_shift == '0) ? '0 : (SUM_W'(1) << (r_shift - SHIFT_BITWIDTH'(1)));
        w_sum     = w_ext + $signed(w_rnd);
        w_shifted = w_sum >>> r_shift;
        if (w_shifted > SAT_MAX) begin
            w_q = SAT_MAX[OUT_BITWIDTH-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_q = SAT_MIN[OUT_BITWIDTH-1:0];
        end else begin
            w_q = w_shifted[OUT_BITWIDTH-1:0];
        end
        w_word = r_pack | (DATA_BITWIDTH'(w_q) << (OUT_BITWIDTH * 32'(r_lane)));
    end

    // Lane packing and ifmap write; a word goes out once lane 3 or the last element lands
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_vld      <= 1'b0;
            r_vld_last <= 1'b0;
            r_lane     <= '0;
            r_pack     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_vld      <= r_rd_en;
            r_vld_last <= w_issue_last;
            r_wr_en    <= 1'b0;
            if (w_accept) begin
                r_shift  <= i_shift;
                r_relu   <= i_relu_en;
                r_wr_ptr <= i_dst_base;
                r_lane   <= '0;
                r_pack   <= '0;
            end else if (r_vld) begin
                if ((r_lane == LANE_BITS'(LANES - 1)) || r_vld_last) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_wr_ptr;
                    r_wr_data <= w_word;
                    r_wr_ptr  <= r_wr_ptr + ADDR_BITWIDTH'(1);
                    r_lane    <= '0;
                    r_pack    <= '0;
                end else begin
                    r_lane <= r_lane + LANE_BITS'(1);
                    r_pack <= w_word;
                end
            end
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_psum_rd_en    = r_rd_en;
    assign o_psum_rd_addr  = r_rd_addr;
    assign o_ifmap_wr_en   = r_wr_en;
    assign o_ifmap_wr_addr = r_wr_addr;
    assign o_ifmap_wr_data = r_wr_data;

endmodule

// File: tb/tb_psum_requant_writeback.sv
// Testbench for psum_requant_writeback: a psum bank model feeds the DUT, and a
// per-cycle monitor records reads, writes, done and busy. Each test task checks
// that record against fixed values or against an arithmetic reference model.
module tb_psum_requant_writeback;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [12:0] i_src_base;
    logic [12:0] i_dst_base;
    logic [13:0] i_num_elem;
    logic [4:0]  i_shift;
    logic        i_relu_en;
    logic        o_busy;
    logic        o_done;
    logic        o_psum_rd_en;
    logic [12:0] o_psum_rd_addr;
    logic [31:0] i_psum_rd_data;
    logic        o_ifmap_wr_en;
    logic [12:0] o_ifmap_wr_addr;
    logic [31:0] o_ifmap_wr_data;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] mem [8192];
    logic [31:0] elem [64];

    int          rd_addr_q[$];
    int          rd_cyc_q[$];
    int          wr_addr_q[$];
    int          wr_cyc_q[$];
    logic [31:0] wr_data_q[$];
    int          done_cyc_q[$];
    int          busy_cnt;

    psum_requant_writeback dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_src_base     (i_src_base),
        .i_dst_base     (i_dst_base),
        .i_num_elem     (i_num_elem),
        .i_shift        (i_shift),
        .i_relu_en      (i_relu_en),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_psum_rd_en   (o_psum_rd_en),
        .o_psum_rd_addr (o_psum_rd_addr),
        .i_psum_rd_data (i_psum_rd_data),
        .o_ifmap_wr_en  (o_ifmap_wr_en),
        .o_ifmap_wr_addr(o_ifmap_wr_addr),
        .o_ifmap_wr_data(o_ifmap_wr_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Psum bank: one-cycle read latency
    always @(posedge i_clk) begin
        if (o_psum_rd_en) i_psum_rd_data <= mem[o_psum_rd_addr];
    end

    // Reference requantization using plain 64-bit integer arithmetic
    function automatic logic [7:0] ref_requant(input logic [31:0] raw, input int sh, input bit relu);
        longint v;
        v = longint'($signed(raw));
        if (relu && v < 0) v = 0;
        if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic logic [31:0] ref_word(input int w, input int n, input int sh, input bit relu);
        logic [31:0] word;
        word = '0;
        for (int k = 4 * w; k < 4 * w + 4 && k < n; k++)
            word = word | (32'(ref_requant(elem[k], sh, relu)) << (8 * (k % 4)));
        return word;
    endfunction

    function automatic int ref_wr_cycle(input int w, input int n);
        int e;
        e = (4 * w + 3 < n - 1) ? 4 * w + 3 : n - 1;
        return e + 3;
    endfunction

    task automatic load_elems(input int src, input int n);
        for (int k = 0; k < n; k++) mem[(src + k) % 8192] = elem[k];
    endtask

    task automatic rand_elems(input int n, input int sh);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) elem[k] = $urandom();
            else elem[k] = 32'($signed($urandom_range(0, 1 << (sh + 9))) - (1 << (sh + 8)));
        end
    endtask

    // Starts a job at edge T and records activity for cycles T+1..T+n+8.
    // A nonzero restart_at pulses i_start (with junk config) in that cycle.
    task automatic run_job(input int src, input int dst, input int n, input int sh,
                           input bit relu, input int restart_at);
        rd_addr_q.delete(); rd_cyc_q.delete();
        wr_addr_q.delete(); wr_cyc_q.delete(); wr_data_q.delete();
        done_cyc_q.delete(); busy_cnt = 0;
        i_src_base = 13'(src); i_dst_base = 13'(dst); i_num_elem = 14'(n);
        i_shift = 5'(sh); i_relu_en = relu; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_src_base = 13'($urandom()); i_dst_base = 13'($urandom());
        i_num_elem = 14'($urandom()); i_shift = 5'($urandom()); i_relu_en = 1'($urandom());
        for (int c = 1; c <= n + 8; c++) begin
            if (o_psum_rd_en) begin rd_addr_q.push_back(int'(o_psum_rd_addr)); rd_cyc_q.push_back(c); end
            if (o_ifmap_wr_en) begin
                wr_addr_q.push_back(int'(o_ifmap_wr_addr)); wr_data_q.push_back(o_ifmap_wr_data);
                wr_cyc_q.push_back(c);
            end
            if (o_done) done_cyc_q.push_back(c);
            if (o_busy) busy_cnt++;
            i_start = (c == restart_at);
            @(posedge i_clk); #1;
        end
        i_start = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        vec_cnt++;
        if ({o_busy, o_done, o_psum_rd_en, o_ifmap_wr_en} !== 4'b0 || o_psum_rd_addr !== 13'd0 ||
            o_ifmap_wr_addr !== 13'd0 || o_ifmap_wr_data !== 32'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d wr_data=%h, expected all 0",
                     o_busy, o_done, o_psum_rd_en, o_ifmap_wr_en, o_psum_rd_addr, o_ifmap_wr_addr, o_ifmap_wr_data);
        end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_basic_pack;
        logic [31:0] exp_w [2];
        elem[0] = 32'd1; elem[1] = 32'd2; elem[2] = 32'd3; elem[3] = 32'd4;
        elem[4] = 32'hFFFFFFFF; elem[5] = 32'hFFFFFFFE; elem[6] = 32'd127; elem[7] = 32'hFFFFFF80;
        load_elems(200, 8);
        run_job(200, 100, 8, 0, 1'b0, 0);
        exp_w[0] = 32'h04030201; exp_w[1] = 32'h807FFEFF;
        vec_cnt++;
        if (wr_data_q.size() != 2) begin
            err_cnt++; $display("FAIL basic_wr_count: got %0d, expected 2", wr_data_q.size());
        end
        for (int w = 0; w < 2 && w < wr_data_q.size(); w++) begin
            vec_cnt++;
            if (wr_data_q[w] !== exp_w[w] || wr_addr_q[w] != 100 + w) begin
                err_cnt++;
                $display("FAIL basic_word%0d: got %h @%0d, expected %h @%0d", w, wr_data_q[w], wr_addr_q[w], exp_w[w], 100 + w);
            end
        end
        vec_cnt++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != 11) begin
            err_cnt++;
            $display("FAIL basic_done_cycle: got %0d pulses first at %0d, expected 1 at 11",
                     done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1);
        end
    endtask

    task automatic test_relu_round;
        elem[0] = 32'hFFFFFFFB; elem[1] = 32'd5; elem[2] = 32'd6; elem[3] = 32'd2;
        load_elems(40, 4);
        run_job(40, 7, 4, 2, 1'b1, 0);
        vec_cnt++;
        if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'h01020100) begin
            err_cnt++;
            $display("FAIL relu_round_word: got %0d writes first %h, expected 1 write 01020100",
                     wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx);
        end
    endtask

    task automatic test_saturation;
        logic [31:0] exp_w [2];
        exp_w[0] = 32'h807F807F; exp_w[1] = 32'h007F007F;
        elem[0] = 32'h00001000; elem[1] = 32'hFFFFF000; elem[2] = 32'h7FFFFFFF; elem[3] = 32'h80000000;
        load_elems(500, 4);
        for (int r = 0; r < 2; r++) begin
            run_job(500, 600, 4, 0, 1'(r), 0);
            vec_cnt++;
            if (wr_data_q.size() != 1 || wr_data_q[0] !== exp_w[r]) begin
                err_cnt++;
                $display("FAIL saturation_relu%0d: got %0d writes first %h, expected 1 write %h",
                         r, wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx, exp_w[r]);
            end
        end
    endtask

    task automatic test_partial_wrap;
        int          exp_rd [5];
        logic [31:0] exp_w1;
        exp_rd[0] = 8190; exp_rd[1] = 8191; exp_rd[2] = 0; exp_rd[3] = 1; exp_rd[4] = 2;
        rand_elems(5, 3);
        load_elems(8190, 5);
        run_job(8190, 8191, 5, 3, 1'b0, 0);
        exp_w1 = 32'(ref_requant(elem[4], 3, 1'b0));
        vec_cnt++;
        if (rd_addr_q.size() != 5) begin
            err_cnt++; $display("FAIL wrap_rd_count: got %0d, expected 5", rd_addr_q.size());
        end
        for (int k = 0; k < 5 && k < rd_addr_q.size(); k++) begin
            vec_cnt++;
            if (rd_addr_q[k] != exp_rd[k]) begin
                err_cnt++; $display("FAIL wrap_rd_addr%0d: got %0d, expected %0d", k, rd_addr_q[k], exp_rd[k]);
            end
        end
        vec_cnt++;
        if (wr_addr_q.size() != 2 || wr_addr_q[0] != 8191 || wr_addr_q[1] != 0) begin
            err_cnt++; $display("FAIL wrap_wr_addrs: got %0d writes, expected 2 at 8191 then 0", wr_addr_q.size());
        end else begin
            vec_cnt++;
            if (wr_data_q[1] !== exp_w1 || wr_data_q[0] !== ref_word(0, 5, 3, 1'b0)) begin
                err_cnt++;
                $display("FAIL wrap_wr_data: got %h %h, expected %h %h", wr_data_q[0], wr_data_q[1],
                         ref_word(0, 5, 3, 1'b0), exp_w1);
            end
        end
    endtask

    task automatic test_zero_length;
        run_job(10, 20, 0, 4, 1'b0, 0);
        vec_cnt++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != 1 || rd_addr_q.size() != 0 ||
            wr_addr_q.size() != 0 || busy_cnt != 0) begin
            err_cnt++;
            $display("FAIL zero_length: done_pulses=%0d first=%0d reads=%0d writes=%0d busy_cycles=%0d, expected 1 at 1,0,0,0",
                     done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1,
                     rd_addr_q.size(), wr_addr_q.size(), busy_cnt);
        end
    endtask

    task automatic test_restart_ignored;
        rand_elems(8, 0);
        load_elems(300, 8);
        run_job(300, 400, 8, 0, 1'b0, 3);
        vec_cnt++;
        if (wr_addr_q.size() != 2 || done_cyc_q.size() != 1 || rd_addr_q.size() != 8) begin
            err_cnt++;
            $display("FAIL restart_ignored: writes=%0d done_pulses=%0d reads=%0d, expected 2,1,8",
                     wr_addr_q.size(), done_cyc_q.size(), rd_addr_q.size());
        end
        for (int w = 0; w < 2 && w < wr_data_q.size(); w++) begin
            vec_cnt++;
            if (wr_data_q[w] !== ref_word(w, 8, 0, 1'b0)) begin
                err_cnt++; $display("FAIL restart_word%0d: got %h, expected %h", w, wr_data_q[w], ref_word(w, 8, 0, 1'b0));
            end
        end
    endtask

    task automatic test_reset_mid_job;
        int stray;
        rand_elems(16, 2);
        load_elems(1000, 16);
        i_src_base = 13'd1000; i_dst_base = 13'd50; i_num_elem = 14'd16;
        i_shift = 5'd2; i_relu_en = 1'b0; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (5) begin @(posedge i_clk); #1; end
        vec_cnt++;
        if (o_psum_rd_en !== 1'b1 || o_busy !== 1'b1) begin
            err_cnt++; $display("FAIL midjob_active: rd_en=%b busy=%b, expected 1 1", o_psum_rd_en, o_busy);
        end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        vec_cnt++;
        if ({o_busy, o_done, o_psum_rd_en, o_ifmap_wr_en} !== 4'b0 || o_psum_rd_addr !== 13'd0 ||
            o_ifmap_wr_addr !== 13'd0 || o_ifmap_wr_data !== 32'd0) begin
            err_cnt++;
            $display("FAIL midjob_reset_outputs: busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d wr_data=%h, expected all 0",
                     o_busy, o_done, o_psum_rd_en, o_ifmap_wr_en, o_psum_rd_addr, o_ifmap_wr_addr, o_ifmap_wr_data);
        end
        i_rst = 1'b0;
        stray = 0;
        repeat (20) begin
            if (o_busy || o_done || o_psum_rd_en || o_ifmap_wr_en) stray++;
            @(posedge i_clk); #1;
        end
        vec_cnt++;
        if (stray != 0) begin
            err_cnt++; $display("FAIL midjob_quiet: got %0d active cycles after reset, expected 0", stray);
        end
        run_job(1000, 50, 16, 2, 1'b0, 0);
        vec_cnt++;
        if (wr_data_q.size() != 4 || done_cyc_q.size() != 1 || done_cyc_q[0] != 19) begin
            err_cnt++;
            $display("FAIL midjob_fresh_job: writes=%0d done_pulses=%0d, expected 4 writes and done at 19",
                     wr_data_q.size(), done_cyc_q.size());
        end
        for (int w = 0; w < 4 && w < wr_data_q.size(); w++) begin
            vec_cnt++;
            if (wr_data_q[w] !== ref_word(w, 16, 2, 1'b0) || wr_addr_q[w] != 50 + w) begin
                err_cnt++;
                $display("FAIL midjob_fresh_word%0d: got %h @%0d, expected %h @%0d", w, wr_data_q[w], wr_addr_q[w],
                         ref_word(w, 16, 2, 1'b0), 50 + w);
            end
        end
    endtask

    task automatic test_random_jobs;
        int  src, dst, n, sh, nw;
        bit  relu;
        for (int j = 0; j < 8; j++) begin
            src  = $urandom_range(0, 8191);
            dst  = $urandom_range(0, 8191);
            n    = $urandom_range(1, 40);
            sh   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 10);
            relu = 1'($urandom());
            nw   = (n + 3) / 4;
            rand_elems(n, (sh > 20) ? 20 : sh);
            load_elems(src, n);
            run_job(src, dst, n, sh, relu, 0);
            vec_cnt++;
            if (rd_addr_q.size() != n) begin
                err_cnt++; $display("FAIL rand%0d_rd_count: got %0d, expected %0d", j, rd_addr_q.size(), n);
            end
            for (int k = 0; k < n && k < rd_addr_q.size(); k++) begin
                vec_cnt++;
                if (rd_addr_q[k] != (src + k) % 8192 || rd_cyc_q[k] != k + 1) begin
                    err_cnt++;
                    $display("FAIL rand%0d_read%0d: got addr %0d cycle %0d, expected addr %0d cycle %0d",
                             j, k, rd_addr_q[k], rd_cyc_q[k], (src + k) % 8192, k + 1);
                end
            end
            vec_cnt++;
            if (wr_data_q.size() != nw) begin
                err_cnt++; $display("FAIL rand%0d_wr_count: got %0d, expected %0d", j, wr_data_q.size(), nw);
            end
            for (int w = 0; w < nw && w < wr_data_q.size(); w++) begin
                vec_cnt++;
                if (wr_data_q[w] !== ref_word(w, n, sh, relu) || wr_addr_q[w] != (dst + w) % 8192 ||
                    wr_cyc_q[w] != ref_wr_cycle(w, n)) begin
                    err_cnt++;
                    $display("FAIL rand%0d_write%0d: got %h @%0d cycle %0d, expected %h @%0d cycle %0d (sh=%0d relu=%0d)",
                             j, w, wr_data_q[w], wr_addr_q[w], wr_cyc_q[w], ref_word(w, n, sh, relu),
                             (dst + w) % 8192, ref_wr_cycle(w, n), sh, relu);
                end
            end
            vec_cnt++;
            if (done_cyc_q.size() != 1 || done_cyc_q[0] != n + 3 || busy_cnt != n + 2) begin
                err_cnt++;
                $display("FAIL rand%0d_done_busy: done_pulses=%0d first=%0d busy_cycles=%0d, expected 1 at %0d busy %0d",
                         j, done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, busy_cnt, n + 3, n + 2);
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0;
        i_src_base = '0; i_dst_base = '0; i_num_elem = '0; i_shift = '0; i_relu_en = 1'b0;
        i_psum_rd_data = '0;
        for (int a = 0; a < 8192; a++) mem[a] = '0;
        test_reset();
        test_basic_pack();
        test_relu_round();
        test_saturation();
        test_partial_wrap();
        test_zero_length();
        test_restart_ignored();
        test_reset_mid_job();
        test_random_jobs();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/psum_requant_writeback.md
Name: psum_requant_writeback

Overview:
- Post-processing stage directly downstream of the eyeriss core. Runs after core done and reads the finished layer's psums out of the GLB psum bank.
- For each psum: optional ReLU, rounded arithmetic right shift, saturation to signed int8.
- Packs four int8 results per 32-bit word and writes them into the GLB ifmap bank as the next layer's ifmap (e.g. conv3 output feeding conv45).
- Driven by the wrapper control FSM: start/done handshake, dedicated BRAM ports.

Parameters:
- DATA_BITWIDTH, 32, psum width and ifmap bank word width.
- ADDR_BITWIDTH, 13, bank address width (BANK_DEPTH 8192).
- OUT_BITWIDTH, 8, requantized element width; DATA_BITWIDTH/OUT_BITWIDTH = 4 lanes per word.
- SHIFT_BITWIDTH, 5, width of the shift amount.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous reset, active-high
- i_start  input  1  one-cycle start pulse; ignored while o_busy=1
- i_src_base  input  ADDR_BITWIDTH  first psum bank address to read
- i_dst_base  input  ADDR_BITWIDTH  first ifmap bank word address to write
- i_num_elem  input  ADDR_BITWIDTH+1  number of psums to process (0..8192)
- i_shift  input  SHIFT_BITWIDTH  right-shift amount (0..31)
- i_relu_en  input  1  1 = clamp negative psums to 0 before the shift
- o_busy  output  1  high from the cycle after start is accepted until the done pulse
- o_done  output  1  one-cycle completion pulse
- o_psum_rd_en  output  1  psum bank read enable
- o_psum_rd_addr  output  ADDR_BITWIDTH  psum bank read address
- i_psum_rd_data  input  DATA_BITWIDTH  psum read data; valid exactly one cycle after o_psum_rd_en
- o_ifmap_wr_en  output  1  ifmap bank write enable
- o_ifmap_wr_addr  output  ADDR_BITWIDTH  ifmap bank write address
- o_ifmap_wr_data  output  DATA_BITWIDTH  packed int8 word

Behaviour:
- Reset: every output is 0, FSM enters IDLE, lane counter and pack register are cleared. Reset in mid-operation aborts immediately. No further reads, writes or done pulse occur. A word already written is not rolled back.
- Start acceptance: i_start sampled in IDLE at edge T latches all configuration inputs. Configuration inputs are don't-care afterwards. i_start while busy has no effect.
- States:
  - IDLE: waiting for start.
  - READ: issue reads.
  - DRAIN: last read data returning.
  - FLUSH: write the final partial word.
  - DONE: pulse o_done, then return to IDLE.
- Zero-length job: i_num_elem=0 goes straight to DONE. o_done is high in cycle T+1. No reads or writes occur, and o_busy stays 0.
- Reads: o_psum_rd_en is high for exactly N consecutive cycles, T+1..T+N. Address is i_src_base+k for k = 0..N-1, wrapping modulo 2^ADDR_BITWIDTH.
- Element pipeline, on data valid in cycle T+2+k:
  - v = signed psum.
  - If relu_en and v<0, v = 0.
  - If shift>0, v = (v + 2^(shift-1)) >>> shift, computed with a 33-bit sum so there is no overflow.
  - Saturate to [-128, 127].
- Packing: element k goes to lane k mod 4, bits [8*lane+7 : 8*lane], little-endian lanes.
- Word write: a word is written in the cycle after its 4th lane is filled, or after the last element if that comes first. Unused lanes of a partial word are 0.
- Write address: i_dst_base + word index, wrapping modulo 2^ADDR_BITWIDTH.
- Write timing: the last write occurs in cycle T+N+2 and o_done pulses in T+N+3. o_ifmap_wr_en is never high in two words' worth of the same data.
- No backpressure: the bank ports are dedicated, and throughput is one element per cycle.

Test Plan:
- Basic pack: N=8, shift=0, relu=0, psums 1,2,3,4,-1,-2,127,-128 → 2 writes: 0x04030201 at dst, 0x807FFEFF at dst+1. o_done in cycle T+11.
- ReLU + rounding: N=4, shift=2, relu=1, psums -5,5,6,2 → lanes 0,1,2,1 → word 0x01020100.
- Saturation: N=4, shift=0, psums 0x00001000, 0xFFFFF000, 0x7FFFFFFF, 0x80000000 → word 0x807F807F. With relu=1 → 0x007F007F.
- Partial word and wrap: N=5, src_base=8190, dst_base=8191 → reads at 8190, 8191, 0, 1, 2. Writes at 8191 then 0; the second word has lanes 1..3 equal to 0.
- Zero length and ignored restart: num_elem=0 → o_done at T+1, no enables. A second i_start during an N=8 job is ignored, and exactly 2 writes plus one o_done occur.
- Reset mid-job: N=16, assert i_rst at T+6 → all outputs 0 from the next cycle. No done pulse. A fresh start afterwards completes normally.
